fd_ring_loader: RTL and testbench

- Parametrised successor to the FAST-9 pixel register bank.
- On a start pulse, autonomously sequences SRAM reads for one centre pixel plus NUM_ADJ circle pixels and captures the returned data.
- Presents centre, packed circle and threshold to the corner-test stage under a valid/ack handshake.
- Sits between the SRAM read port and the FAST comparator.

---
 rtl/fd_ring_loader_pkg.sv | 23 ++
 rtl/fd_ring_loader_capture_bank.sv | 39 +++
 rtl/fd_ring_loader.sv | 228 ++++++++++++++++++++++
 tb/tb_fd_ring_loader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fd_ring_loader_pkg.sv
// fd_pkg: shared types and default constants for the FAST ring loader.
//   fd_state_e : loader FSM state (IDLE/READ/DRAIN/HOLD)
//   FD_*       : default parameter values used by fd_ring_loader
//   slot_t     : slot index for the default configuration (0 = centre)
package fd_pkg;

  localparam int FD_PIX_W     = 8;
  localparam int FD_NUM_ADJ   = 16;
  localparam int FD_ADDR_W    = 5;
  localparam int FD_THRES_W   = 6;
  localparam int FD_DEF_THRES = 30;
  localparam int FD_SRAM_LAT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } fd_state_e;

  typedef logic [FD_ADDR_W-1:0] slot_t;

endpackage

// File: rtl/fd_ring_loader_capture_bank.sv
// fd_capture_bank: NUM_ADJ+1 enable-written pixel registers.
//   clock, reset : rising-edge clock, async active-high reset (clears all slots)
//   i_we         : write strobe for slot i_slot
//   i_slot       : 0 = centre, k = circle pixel k
//   i_data       : pixel to store
//   o_ref        : centre pixel
//   o_adj        : circle pixels packed, pixel 1 in MSBs, pixel NUM_ADJ in LSBs
module fd_capture_bank #(
  parameter int PIX_W   = 8,
  parameter int NUM_ADJ = 16,
  parameter int ADDR_W  = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_we,
  input  logic [ADDR_W-1:0]        i_slot,
  input  logic [PIX_W-1:0]         i_data,
  output logic [PIX_W-1:0]         o_ref,
  output logic [NUM_ADJ*PIX_W-1:0] o_adj
);

  logic [NUM_ADJ:0][PIX_W-1:0] r_slot;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_slot <= '0;
    end else if (i_we) begin
      for (int k = 0; k <= NUM_ADJ; k++)
        if (i_slot == ADDR_W'(k)) r_slot[k] <= i_data;
    end
  end

  assign o_ref = r_slot[0];

  for (genvar k = 1; k <= NUM_ADJ; k++) begin : g_pack
    assign o_adj[(NUM_ADJ-k)*PIX_W +: PIX_W] = r_slot[k];
  end

endmodule

// File: rtl/fd_ring_loader.sv
// fd_ring_loader: on start, reads centre + NUM_ADJ circle pixels from SRAM,
// captures them and presents them with a threshold snapshot under valid/ack.
//   clock, reset        : rising-edge clock, async active-high reset
//   start               : begin a load (accepted only when the loader is idle)
//   sramRen, regAddr    : SRAM read strobe and slot index (0 = centre)
//   sramData            : read data, SRAM_LAT cycles after sramRen
//   thresIn, thresWe    : live threshold write port (any state)
//   busy                : load in progress
//   valid, ack          : result handshake
//   refPixel, adjPixel  : centre pixel, packed circle (pixel 1 in MSBs)
//   thres               : threshold snapshot taken on the starting edge
// All result outputs read 0 while valid is low.
// Optional: FD_RING_DBLBUF_EN adds a shadow capture bank so a new load can
// run while a result is held, giving back-to-back results on ack.
module fd_ring_loader
  import fd_pkg::*;
#(
  parameter int PIX_W     = FD_PIX_W,
  parameter int NUM_ADJ   = FD_NUM_ADJ,
  parameter int ADDR_W    = FD_ADDR_W,
  parameter int THRES_W   = FD_THRES_W,
  parameter int DEF_THRES = FD_DEF_THRES,
  parameter int SRAM_LAT  = FD_SRAM_LAT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  output logic                     sramRen,
  output logic [ADDR_W-1:0]        regAddr,
  input  logic [PIX_W-1:0]         sramData,
  input  logic [THRES_W-1:0]       thresIn,
  input  logic                     thresWe,
  output logic                     busy,
  output logic                     valid,
  input  logic                     ack,
  output logic [PIX_W-1:0]         refPixel,
  output logic [NUM_ADJ*PIX_W-1:0] adjPixel,
  output logic [THRES_W-1:0]       thres
);

  localparam int CNT_W = (SRAM_LAT < 2) ? 1 : $clog2(SRAM_LAT);
`ifdef FD_RING_DBLBUF_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  fd_state_e                 r_state;
  logic [ADDR_W-1:0]         r_addr;
  logic [CNT_W-1:0]          r_cnt;
  logic [THRES_W-1:0]        r_thres_live;
  logic [SRAM_LAT:1]         r_vld_pipe;
  logic [SRAM_LAT:1][ADDR_W-1:0] r_tag_pipe;

  logic                      w_start_ok;
  logic                      w_last_slot;
  logic                      w_drain_done;
  fd_state_e                 w_after_drain;
  logic [NBANK-1:0]          w_cap_we;
  logic [NBANK-1:0][PIX_W-1:0]         w_bank_ref;
  logic [NBANK-1:0][NUM_ADJ*PIX_W-1:0] w_bank_adj;
  logic [PIX_W-1:0]          w_ref;
  logic [NUM_ADJ*PIX_W-1:0]  w_adj;
  logic [THRES_W-1:0]        w_thres;

  assign w_last_slot  = (r_addr == ADDR_W'(NUM_ADJ));
  assign w_drain_done = (r_cnt == CNT_W'(SRAM_LAT-1));
  assign sramRen      = (r_state == ST_READ);
  assign regAddr      = r_addr;

  // Load sequencer: READ issues slots 0..NUM_ADJ, DRAIN waits out the
  // SRAM return latency so the last slot is captured before valid rises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_start_ok) begin
          r_state <= ST_READ;
          r_addr  <= '0;
        end
        ST_READ: if (w_last_slot) begin
          r_state <= ST_DRAIN;
          r_addr  <= '0;
          r_cnt   <= '0;
        end else begin
          r_addr  <= r_addr + 1'b1;
        end
        ST_DRAIN: if (w_drain_done) r_state <= w_after_drain;
                  else              r_cnt   <= r_cnt + 1'b1;
        ST_HOLD:  if (ack) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        r_thres_live <= THRES_W'(DEF_THRES);
    else if (thresWe) r_thres_live <= thresIn;
  end

  // Tag pipeline: a read's slot index travels alongside it so returning
  // data lands in the right register. Reset flushes in-flight reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_tag_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= sramRen;
      r_tag_pipe[1] <= r_addr;
      for (int i = 2; i <= SRAM_LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_tag_pipe[i] <= r_tag_pipe[i-1];
      end
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    fd_capture_bank #(
      .PIX_W(PIX_W), .NUM_ADJ(NUM_ADJ), .ADDR_W(ADDR_W)
    ) u_bank (
      .clock  (clock),
      .reset  (reset),
      .i_we   (w_cap_we[b]),
      .i_slot (r_tag_pipe[SRAM_LAT]),
      .i_data (sramData),
      .o_ref  (w_bank_ref[b]),
      .o_adj  (w_bank_adj[b])
    );
  end

`ifdef FD_RING_DBLBUF_EN
  // Loader and presentation run independently: the loader returns to IDLE
  // after DRAIN, and a finished load is either presented at once or parked
  // as pending until the consumer acks the front bank.
  logic                      r_ld_bank;
  logic                      r_pres_bank;
  logic                      r_valid;
  logic                      r_pend;
  logic [1:0][THRES_W-1:0]   r_thres_snap;
  logic [SRAM_LAT:1]         r_bank_pipe;
  logic                      w_nb;
  logic                      w_done;
  logic                      w_take;

  assign w_start_ok    = (r_state == ST_IDLE) && start && !r_pend;
  assign w_after_drain = ST_IDLE;
  assign w_nb          = r_valid ? ~r_pres_bank : r_pres_bank;
  assign w_done        = (r_state == ST_DRAIN) && w_drain_done;
  assign w_take        = r_valid && ack;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bank_pipe <= '0;
    end else begin
      r_bank_pipe[1] <= r_ld_bank;
      for (int i = 2; i <= SRAM_LAT; i++) r_bank_pipe[i] <= r_bank_pipe[i-1];
    end
  end

  assign w_cap_we = {r_vld_pipe[SRAM_LAT] &  r_bank_pipe[SRAM_LAT],
                     r_vld_pipe[SRAM_LAT] & ~r_bank_pipe[SRAM_LAT]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ld_bank    <= 1'b0;
      r_pres_bank  <= 1'b0;
      r_valid      <= 1'b0;
      r_pend       <= 1'b0;
      r_thres_snap <= '0;
    end else begin
      if (w_start_ok) begin
        r_ld_bank          <= w_nb;
        r_thres_snap[w_nb] <= r_thres_live;
      end
      // A pending shadow and a finishing load never coexist: start is
      // blocked while a shadow result is pending.
      if (w_take) begin
        if (r_pend) begin
          r_pres_bank <= ~r_pres_bank;
          r_pend      <= 1'b0;
        end else if (w_done) begin
          r_pres_bank <= r_ld_bank;
        end else begin
          r_valid     <= 1'b0;
        end
      end else if (w_done) begin
        if (r_valid) r_pend <= 1'b1;
        else begin
          r_valid     <= 1'b1;
          r_pres_bank <= r_ld_bank;
        end
      end
    end
  end

  assign valid   = r_valid;
  assign busy    = (r_state != ST_IDLE);
  assign w_ref   = w_bank_ref[r_pres_bank];
  assign w_adj   = w_bank_adj[r_pres_bank];
  assign w_thres = r_thres_snap[r_pres_bank];
`else
  logic [THRES_W-1:0] r_thres_snap;

  assign w_start_ok    = (r_state == ST_IDLE) && start;
  assign w_after_drain = ST_HOLD;
  assign w_cap_we[0]   = r_vld_pipe[SRAM_LAT];

  // Snapshot reads the register before any same-edge thresWe lands.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           r_thres_snap <= '0;
    else if (w_start_ok) r_thres_snap <= r_thres_live;
  end

  assign valid   = (r_state == ST_HOLD);
  assign busy    = (r_state == ST_READ) || (r_state == ST_DRAIN);
  assign w_ref   = w_bank_ref[0];
  assign w_adj   = w_bank_adj[0];
  assign w_thres = r_thres_snap;
`endif

  assign refPixel = valid ? w_ref   : '0;
  assign adjPixel = valid ? w_adj   : '0;
  assign thres    = valid ? w_thres : '0;

endmodule

// File: tb/tb_fd_ring_loader.sv
// Directed bench for fd_ring_loader: default instance (A) and a
// SRAM_LAT=3 / NUM_ADJ=12 / ADDR_W=4 instance (B). SRAM models return
// base+slot after the configured latency.
module tb_fd_ring_loader;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // instance A (defaults)
  logic         start_a = 0, ack_a = 0, thresWe_a = 0;
  logic [5:0]   thresIn_a = 0;
  logic         sramRen_a, busy_a, valid_a;
  logic [4:0]   regAddr_a;
  logic [7:0]   sramData_a, refPixel_a;
  logic [127:0] adjPixel_a;
  logic [5:0]   thres_a;

  // instance B (latency sweep)
  logic         start_b = 0, ack_b = 0, thresWe_b = 0;
  logic [5:0]   thresIn_b = 0;
  logic         sramRen_b, busy_b, valid_b;
  logic [3:0]   regAddr_b;
  logic [7:0]   sramData_b, refPixel_b;
  logic [95:0]  adjPixel_b;
  logic [5:0]   thres_b;

  logic [7:0] base = 8'h10;
  logic       noise = 1'b0;
  logic [7:0] noise_val = 8'h00;
  logic [7:0] da1 = 8'hEE, db1 = 8'hEE, db2 = 8'hEE, db3 = 8'hEE;

  always @(posedge clock) begin
    da1 <= sramRen_a ? base + 8'(regAddr_a) : 8'hEE;
    db1 <= sramRen_b ? base + 8'(regAddr_b) : 8'hEE;
    db2 <= db1;
    db3 <= db2;
  end
  assign sramData_a = noise ? noise_val : da1;
  assign sramData_b = db3;

  fd_ring_loader u_a (
    .clock(clock), .reset(reset), .start(start_a), .sramRen(sramRen_a),
    .regAddr(regAddr_a), .sramData(sramData_a), .thresIn(thresIn_a),
    .thresWe(thresWe_a), .busy(busy_a), .valid(valid_a), .ack(ack_a),
    .refPixel(refPixel_a), .adjPixel(adjPixel_a), .thres(thres_a)
  );

  fd_ring_loader #(.NUM_ADJ(12), .ADDR_W(4), .SRAM_LAT(3)) u_b (
    .clock(clock), .reset(reset), .start(start_b), .sramRen(sramRen_b),
    .regAddr(regAddr_b), .sramData(sramData_b), .thresIn(thresIn_b),
    .thresWe(thresWe_b), .busy(busy_b), .valid(valid_b), .ack(ack_b),
    .refPixel(refPixel_b), .adjPixel(adjPixel_b), .thres(thres_b)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_adj(input logic [7:0] b, input int n);
    logic [127:0] e = '0;
    for (int k = 1; k <= n; k++) e[(n-k)*8 +: 8] = b + 8'(k);
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic launch_a(input logic we, input logic [5:0] tin);
    start_a = 1; thresWe_a = we; thresIn_a = tin;
    tick();
    start_a = 0; thresWe_a = 0;
  endtask

  // Counts cycles from the start cycle (0) until valid; optionally pulses
  // start again at cycle pulse_at.
  task automatic wait_valid_a(input int pulse_at, output int lat);
    lat = 1;
    while (!valid_a && lat < 100) begin
      start_a = (lat == pulse_at);
      tick();
      lat++;
    end
    start_a = 0;
  endtask

  task automatic ack_pulse_a();
    ack_a = 1;
    tick();
    ack_a = 0;
  endtask

  int lat;
  int k;

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_ren", sramRen_a, 0);
    check("rst_addr", regAddr_a, 0);
    check("rst_ref", refPixel_a, 0);
    check("rst_thres", thres_a, 0);
    reset = 0;
    tick();

    // basic load
    launch_a(0, 6'd0);
    check("ren_in_read", sramRen_a, 1);
    check("busy_in_read", busy_a, 1);
    wait_valid_a(0, lat);
    check("basic_latency", lat, 19);
    check("basic_ref", refPixel_a, 8'h10);
    check("basic_adj_msb", adjPixel_a[127:120], 8'h11);
    check("basic_adj_lsb", adjPixel_a[7:0], 8'h20);
    check("basic_adj", adjPixel_a, exp_adj(8'h10, 16));
    check("basic_thres", thres_a, 30);
    check("basic_busy", busy_a, 0);

    // hold stability with noisy SRAM data and an ignored start
    noise = 1;
    for (int i = 0; i < 50; i++) begin
      noise_val = 8'($urandom);
      start_a = (i == 20);
      tick();
      if (i % 10 == 9) begin
        check("hold_valid", valid_a, 1);
        check("hold_ref", refPixel_a, 8'h10);
        check("hold_adj", adjPixel_a, exp_adj(8'h10, 16));
        check("hold_busy", busy_a, 0);
      end
    end
    start_a = 0;
    noise = 0;
    ack_pulse_a();
    check("ack_valid", valid_a, 0);
    check("ack_ref", refPixel_a, 0);
    check("ack_adj", adjPixel_a, 0);
    check("ack_thres", thres_a, 0);
    // ack in IDLE, and no queued start from HOLD
    ack_a = 1;
    tick(); tick();
    ack_a = 0;
    check("idle_ack_valid", valid_a, 0);
    check("idle_ack_busy", busy_a, 0);

    // threshold write on the start edge, plus start during READ ignored
    launch_a(1, 6'd12);
    wait_valid_a(5, lat);
    check("thr_latency", lat, 19);
    check("thr_old", thres_a, 30);
    // start and ack together in HOLD: ack wins
    start_a = 1; ack_a = 1;
    tick();
    start_a = 0; ack_a = 0;
    check("startack_valid", valid_a, 0);
    check("startack_busy", busy_a, 0);
    tick();
    check("startack_busy2", busy_a, 0);
    launch_a(0, 6'd0);
    wait_valid_a(0, lat);
    check("thr2_latency", lat, 19);
    check("thr_new", thres_a, 12);
    ack_pulse_a();

    // reset while reading slot 7
    launch_a(0, 6'd0);
    k = 0;
    while (regAddr_a != 5'd7 && k < 40) begin
      tick();
      k++;
    end
    check("reach_slot7", regAddr_a, 7);
    reset = 1;
    #1;
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_ren", sramRen_a, 0);
    check("mid_rst_addr", regAddr_a, 0);
    check("mid_rst_valid", valid_a, 0);
    #1;
    reset = 0;
    base = 8'h40;
    tick();
    launch_a(0, 6'd0);
    wait_valid_a(0, lat);
    check("post_rst_latency", lat, 19);
    check("post_rst_ref", refPixel_a, 8'h40);
    check("post_rst_adj", adjPixel_a, exp_adj(8'h40, 16));
    check("post_rst_thres", thres_a, 30);
    ack_pulse_a();

    // latency sweep on instance B
    base = 8'h10;
    start_b = 1;
    tick();
    start_b = 0;
    lat = 1;
    while (!valid_b && lat < 100) begin
      tick();
      lat++;
    end
    check("b_latency", lat, 17);
    check("b_ref", refPixel_b, 8'h10);
    check("b_adj", adjPixel_b, exp_adj(8'h10, 12));
    check("b_thres", thres_b, 30);
    ack_b = 1;
    tick();
    ack_b = 0;
    check("b_ack_valid", valid_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
